// File: rtl/micro_op_queue_pkg.sv
// Shared micro-op types for the decode cracker and the micro-op queue.
package micro_op_queue_pkg;

  localparam int MAX_MOP_CNT = 4;
  localparam int MOPQ_DEPTH  = 16;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } micro_op_t;

  typedef struct packed {
    micro_op_t mop;
    logic      last;
  } mop_q_entry_t;

endpackage

// File: rtl/micro_op_queue.sv
// In-order micro-op FIFO: one whole cracked bundle in per cycle, one mop out per cycle.
module micro_op_queue
  import micro_op_queue_pkg::*;
#(
  parameter int DEPTH = MOPQ_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [2:0]                      in_cnt,
  input  micro_op_t [0:MAX_MOP_CNT-1]     in_mops,
  output logic                            in_ready,
  output logic                            out_valid,
  output micro_op_t                       out_mop,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [CNT_W-1:0]                occupancy,
  output logic                            bad_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  mop_q_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] occ;
  logic             bad_q;
  logic             push_hs, cnt_ok, push, pop;

  // Admission looks only at start-of-cycle occupancy so in_ready never depends on out_ready.
  assign in_ready  = (CNT_W'(DEPTH) - occ) >= CNT_W'(MAX_MOP_CNT);
  assign push_hs   = in_valid && in_ready;
  assign cnt_ok    = in_cnt <= 3'(MAX_MOP_CNT);
  assign push      = push_hs && cnt_ok && !flush;
  assign out_valid = occ != '0;
  assign pop       = out_valid && out_ready && !flush;

  assign out_mop   = mem[head].mop;
  assign out_last  = out_valid && mem[head].last;
  assign occupancy = occ;
  assign bad_cnt   = bad_q;

  // Storage is never reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_MOP_CNT; i++) begin
      if (push && 3'(i) < in_cnt)
        mem[tail + PTR_W'(i)] <= '{mop: in_mops[i], last: (3'(i) == in_cnt - 3'd1)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
      bad_q <= 1'b0;
    end else begin
      bad_q <= push_hs && !cnt_ok && !flush;
      if (flush) begin
        head <= '0;
        tail <= '0;
        occ  <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(in_cnt);
        if (pop)  head <= head + PTR_W'(1);
        occ <= occ + (push ? CNT_W'(in_cnt) : '0) - (pop ? CNT_W'(1) : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (occ <= CNT_W'(DEPTH)) else $error("micro_op_queue occupancy %0d exceeds depth", occ);
  end

endmodule

// File: tb/tb_micro_op_queue.sv
// Directed vector bench for micro_op_queue: table-driven core cases plus fill/drain and wrap sequences.
module tb_micro_op_queue;
  import micro_op_queue_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset, flush, in_valid, out_ready;
  logic [2:0]                  in_cnt;
  micro_op_t [0:MAX_MOP_CNT-1] in_mops;
  logic                        in_ready, out_valid, out_last, bad_cnt;
  micro_op_t                   out_mop;
  logic [4:0]                  occupancy;

  int n_vec = 0;
  int n_err = 0;

  micro_op_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_cnt(in_cnt),
    .in_mops(in_mops), .in_ready(in_ready), .out_valid(out_valid), .out_mop(out_mop),
    .out_last(out_last), .out_ready(out_ready), .occupancy(occupancy), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [2:0] cnt;
    logic [7:0] base;
    logic       ordy;
    logic       fl;
    logic [4:0] e_occ;
    logic       e_ov;
    logic [7:0] e_tag;
    logic       e_last;
    logic       e_ir;
    logic       e_bad;
  } vec_t;

  vec_t vq[$];

  function automatic micro_op_t mk(input logic [7:0] tag);
    micro_op_t m;
    m.opcode = tag;
    m.rd     = tag[4:0];
    m.rs1    = ~tag[4:0];
    m.rs2    = tag[7:3];
    m.imm    = {tag[3:0], tag};
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [2:0] cnt, input logic [7:0] base,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_cnt    = cnt;
    out_ready = ordy;
    flush     = fl;
    for (int i = 0; i < MAX_MOP_CNT; i++) in_mops[i] = mk(base + 8'(i));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic add(input logic iv, input logic [2:0] cnt, input logic [7:0] base, input logic ordy,
                     input logic fl, input logic [4:0] occ, input logic ov, input logic [7:0] tag,
                     input logic last, input logic ir, input logic bad);
    vq.push_back('{iv, cnt, base, ordy, fl, occ, ov, tag, last, ir, bad});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, m;
    // iv cnt base ordy fl | occ ov tag last ir bad  (expected values seen before the cycle's edge)
    add(1, 3, 8'h10, 1, 0,   0, 0, 8'h00, 0, 1, 0);  // push A,B,C
    add(0, 0, 8'h00, 1, 0,   3, 1, 8'h10, 0, 1, 0);
    add(0, 0, 8'h00, 1, 0,   2, 1, 8'h11, 0, 1, 0);
    add(0, 0, 8'h00, 1, 0,   1, 1, 8'h12, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 1, 0);  // in_cnt==0 handshake
    add(1, 7, 8'h20, 1, 0,   0, 0, 8'h00, 0, 1, 0);  // bad count
    add(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 1, 1);
    add(1, 4, 8'h30, 0, 0,   0, 0, 8'h00, 0, 1, 0);
    add(1, 1, 8'h34, 0, 0,   4, 1, 8'h30, 0, 1, 0);
    add(1, 2, 8'h40, 1, 0,   5, 1, 8'h30, 0, 1, 0);  // push 2 + pop at occ 5
    add(0, 0, 8'h00, 0, 0,   6, 1, 8'h31, 0, 1, 0);
    add(0, 0, 8'h00, 1, 0,   6, 1, 8'h31, 0, 1, 0);
    add(0, 0, 8'h00, 1, 0,   5, 1, 8'h32, 0, 1, 0);
    add(0, 0, 8'h00, 1, 0,   4, 1, 8'h33, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0,   3, 1, 8'h34, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0,   2, 1, 8'h40, 0, 1, 0);
    add(0, 0, 8'h00, 1, 0,   1, 1, 8'h41, 1, 1, 0);
    add(1, 4, 8'h50, 0, 0,   0, 0, 8'h00, 0, 1, 0);
    add(1, 4, 8'h54, 0, 0,   4, 1, 8'h50, 0, 1, 0);
    add(1, 1, 8'h58, 0, 0,   8, 1, 8'h50, 0, 1, 0);
    add(1, 4, 8'h60, 1, 1,   9, 1, 8'h50, 0, 1, 0);  // flush with push+pop
    add(1, 1, 8'h70, 1, 0,   0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 1, 0,   1, 1, 8'h70, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 1, 0);

    reset_dut();
    foreach (vq[k]) begin
      drive(vq[k].iv, vq[k].cnt, vq[k].base, vq[k].ordy, vq[k].fl);
      #4;
      chk($sformatf("v%0d occupancy", k), 64'(occupancy), 64'(vq[k].e_occ));
      chk($sformatf("v%0d out_valid", k), 64'(out_valid), 64'(vq[k].e_ov));
      chk($sformatf("v%0d out_last", k),  64'(out_last),  64'(vq[k].e_last));
      chk($sformatf("v%0d in_ready", k),  64'(in_ready),  64'(vq[k].e_ir));
      chk($sformatf("v%0d bad_cnt", k),   64'(bad_cnt),   64'(vq[k].e_bad));
      if (vq[k].e_ov) chk($sformatf("v%0d out_mop", k), 64'(out_mop), 64'(mk(vq[k].e_tag)));
      next_cycle();
    end

    // Fill with 4-wide bundles, no consumer: exactly four bundles fit.
    reset_dut();
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 3'd4, 8'h80 + 8'(4 * acc), 1'b0, 1'b0);
      #4;
      if (!in_ready) break;
      acc++;
      next_cycle();
    end
    chk("fill bundles", 64'(acc), 64'd4);
    chk("fill occupancy", 64'(occupancy), 64'd16);
    chk("fill in_ready", 64'(in_ready), 64'd0);
    next_cycle();
    m = 16;
    for (int j = 0; j < 16; j++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
      #4;
      chk($sformatf("drain%0d mop", j), 64'(out_mop), 64'(mk(8'h80 + 8'(j))));
      chk($sformatf("drain%0d last", j), 64'(out_last), 64'((j % 4) == 3));
      chk($sformatf("drain%0d occupancy", j), 64'(occupancy), 64'(m));
      chk($sformatf("drain%0d in_ready", j), 64'(in_ready), 64'(m <= 12));
      next_cycle();
      m--;
    end
    #4;
    chk("drain empty", 64'(out_valid), 64'd0);
    next_cycle();

    // Wrap: advance head/tail to 14, then a 4-wide bundle spans 14,15,0,1.
    reset_dut();
    drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 3'd4, 8'h04, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 3'd4, 8'h08, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 3'd2, 8'h0C, 1'b0, 1'b0); next_cycle();
    drive(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    #4;
    chk("wrap prefill occupancy", 64'(occupancy), 64'd14);
    next_cycle();
    repeat (13) next_cycle();
    drive(1'b1, 3'd4, 8'hA0, 1'b1, 1'b0);
    #4;
    chk("wrap pre empty", 64'(out_valid), 64'd0);
    next_cycle();
    drive(1'b1, 3'd1, 8'hB0, 1'b1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      #4;
      chk($sformatf("wrap%0d mop", j), 64'(out_mop), 64'(mk(j < 4 ? 8'hA0 + 8'(j) : 8'hB0)));
      chk($sformatf("wrap%0d last", j), 64'(out_last), 64'(j >= 3));
      next_cycle();
      drive(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    end
    #4;
    chk("wrap end empty", 64'(occupancy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
